instr_fetch_unit: RTL and testbench

- Fetch stage that feeds 32-bit MIPS instruction words into the ALU/execute stage.
- Holds the PC and issues word reads to a synchronous instruction memory with 1-cycle read latency.
- Buffers returned words in a small prefetch FIFO and hands them downstream over a valid/ready handshake, each tagged with its PC.
- Supports start, redirect (jump/branch flush) and a halt sentinel.

---
 rtl/instr_fetch_unit.sv | 155 +++++++++++++++
 tb/tb_instr_fetch_unit.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC + 1-cycle sync imem reads into a prefetch FIFO, delivered with their PC over valid/ready.
// Latency: first word visible two cycles after start/redirect; sustains one word per cycle.
// Backpressure: reads stop once FIFO occupancy plus the in-flight read reach FIFO_DEPTH. FETCH_PERF_CNT_EN adds perf counters.
module instr_fetch_unit #(
    parameter int          ADDR_W     = 8,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [31:0] HALT_WORD  = 32'hFFFF_FFFF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_addr,
    output logic              imem_rd_en,
    output logic [ADDR_W-1:0] imem_rd_addr,
    input  logic [31:0]       imem_rd_data,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [31:0]       instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              halted
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]       perf_fetch_cnt,
    output logic [31:0]       perf_stall_cnt
`endif
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HALT = 2'd2;

    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_pc;
    logic              r_inflight;
    logic [ADDR_W-1:0] r_inflight_pc;

    logic [31:0]       r_fifo_dat [FIFO_DEPTH];
    logic [ADDR_W-1:0] r_fifo_pc  [FIFO_DEPTH];
    logic [PW-1:0]     r_wr_ptr;
    logic [PW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;

    logic w_issue;
    logic w_ret_halt;
    logic w_enq;
    logic w_deq;

    // The in-flight read reserves a slot, so a returning word always has room.
    assign w_issue    = (r_state == ST_RUN) && !redirect_valid &&
                        ((r_count + CW'(r_inflight)) < CW'(FIFO_DEPTH));
    assign w_ret_halt = r_inflight && (imem_rd_data == HALT_WORD);
    assign w_enq      = r_inflight && !w_ret_halt && !redirect_valid && (r_state != ST_HALT);
    assign w_deq      = instr_valid && instr_ready;

    assign imem_rd_en   = w_issue;
    assign imem_rd_addr = r_pc;
    assign instr_valid  = (r_count != '0);
    assign instr        = instr_valid ? r_fifo_dat[r_rd_ptr] : '0;
    assign instr_pc     = instr_valid ? r_fifo_pc[r_rd_ptr]  : '0;
    assign halted       = (r_state == ST_HALT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_pc          <= '0;
            r_inflight    <= 1'b0;
            r_inflight_pc <= '0;
        end else if (redirect_valid) begin
            r_state    <= ST_RUN;
            r_pc       <= redirect_addr;
            r_inflight <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state <= ST_RUN;
                        r_pc    <= start_addr;
                    end
                end
                ST_RUN: begin
                    if (w_ret_halt) begin
                        r_state <= ST_HALT;
                    end
                end
                default: ;
            endcase
            if (w_issue) begin
                r_pc          <= r_pc + ADDR_W'(1);
                r_inflight_pc <= r_pc;
            end
            // A read issued alongside a returning halt word is abandoned.
            r_inflight <= w_issue && !w_ret_halt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (redirect_valid) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_enq) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_deq) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: contents are masked by the occupancy count.
    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_fifo_dat[r_wr_ptr] <= imem_rd_data;
            r_fifo_pc[r_wr_ptr]  <= r_inflight_pc;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_perf_fetch_cnt;
    logic [31:0] r_perf_stall_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_fetch_cnt <= '0;
            r_perf_stall_cnt <= '0;
        end else begin
            if (w_deq && (r_perf_fetch_cnt != 32'hFFFF_FFFF)) begin
                r_perf_fetch_cnt <= r_perf_fetch_cnt + 32'd1;
            end
            if (instr_valid && !instr_ready && (r_perf_stall_cnt != 32'hFFFF_FFFF)) begin
                r_perf_stall_cnt <= r_perf_stall_cnt + 32'd1;
            end
        end
    end

    assign perf_fetch_cnt = r_perf_fetch_cnt;
    assign perf_stall_cnt = r_perf_stall_cnt;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: reset, straight fetch, backpressure, redirect, halt, PC wrap.
module tb_instr_fetch_unit;

    localparam int          ADDR_W = 8;
    localparam logic [31:0] HALT_W = 32'hFFFF_FFFF;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic [ADDR_W-1:0] start_addr;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_addr;
    logic              imem_rd_en;
    logic [ADDR_W-1:0] imem_rd_addr;
    logic [31:0]       imem_rd_data;
    logic              instr_valid;
    logic              instr_ready;
    logic [31:0]       instr;
    logic [ADDR_W-1:0] instr_pc;
    logic              halted;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0]       perf_fetch_cnt;
    logic [31:0]       perf_stall_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    logic [31:0] mem [256];

    instr_fetch_unit #(.ADDR_W(ADDR_W), .FIFO_DEPTH(4), .HALT_WORD(HALT_W)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .start_addr     (start_addr),
        .redirect_valid (redirect_valid),
        .redirect_addr  (redirect_addr),
        .imem_rd_en     (imem_rd_en),
        .imem_rd_addr   (imem_rd_addr),
        .imem_rd_data   (imem_rd_data),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .halted         (halted)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (imem_rd_en) imem_rd_data <= mem[imem_rd_addr];
    end

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        start = 1'b0;
        redirect_valid = 1'b0;
        instr_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic do_start(input logic [ADDR_W-1:0] a);
        start = 1'b1;
        start_addr = a;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_valid(input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            if (instr_valid) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        int rd_seen;
        rst_n = 1'b0;
        start = 1'b0; start_addr = '0;
        redirect_valid = 1'b0; redirect_addr = '0;
        instr_ready = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", instr_valid); end
        checks++; if (imem_rd_en !== 1'b0) begin failures++; $display("FAIL rst_rd_en got=%b exp=0", imem_rd_en); end
        rst_n = 1'b1;
        @(negedge clk);
        do_start(8'h10);
        repeat (3) @(negedge clk);
        checks++; if (instr_valid !== 1'b1) begin failures++; $display("FAIL pre_reset_valid got=%b exp=1", instr_valid); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL async_rst_valid got=%b exp=0", instr_valid); end
        checks++; if (instr !== 32'h0) begin failures++; $display("FAIL async_rst_instr got=%h exp=0", instr); end
        checks++; if (instr_pc !== 8'h0) begin failures++; $display("FAIL async_rst_pc got=%h exp=0", instr_pc); end
        checks++; if (imem_rd_en !== 1'b0) begin failures++; $display("FAIL async_rst_rd_en got=%b exp=0", imem_rd_en); end
        checks++; if (imem_rd_addr !== 8'h0) begin failures++; $display("FAIL async_rst_rd_addr got=%h exp=0", imem_rd_addr); end
        checks++; if (halted !== 1'b0) begin failures++; $display("FAIL async_rst_halted got=%b exp=0", halted); end
        @(negedge clk);
        rst_n = 1'b1;
        rd_seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (imem_rd_en !== 1'b0) rd_seen++;
        end
        checks++; if (rd_seen != 0) begin failures++; $display("FAIL idle_no_read got=%0d exp=0", rd_seen); end
    endtask

    task automatic test_straight();
        apply_reset();
        instr_ready = 1'b1;
        do_start(8'h10);
        #1;
        checks++; if (imem_rd_en !== 1'b1 || imem_rd_addr !== 8'h10) begin failures++; $display("FAIL first_read got=%b/%h exp=1/10", imem_rd_en, imem_rd_addr); end
        @(negedge clk);
        checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL valid_early got=%b exp=0", instr_valid); end
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (instr_valid !== 1'b1 || instr !== 32'h01B1001B + 32'(i) || instr_pc !== 8'(8'h10 + i)) begin
                failures++;
                $display("FAIL straight_%0d got=%b/%h/%h exp=1/%h/%h", i, instr_valid, instr, instr_pc, 32'h01B1001B + 32'(i), 8'(8'h10 + i));
            end
            @(negedge clk);
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        apply_reset();
        do_start(8'h10);
        wait_valid(10, ok);
        checks++; if (!ok) begin failures++; $display("FAIL bp_first_valid got=timeout exp=valid"); end
        repeat (10) begin
            @(negedge clk);
            checks++;
            if (instr_valid !== 1'b1 || instr !== 32'h01B1001B || instr_pc !== 8'h10) begin
                failures++;
                $display("FAIL bp_hold got=%b/%h/%h exp=1/01b1001b/10", instr_valid, instr, instr_pc);
            end
        end
        #1;
        checks++; if (imem_rd_en !== 1'b0) begin failures++; $display("FAIL bp_full_no_read got=%b exp=0", imem_rd_en); end
        instr_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (instr_valid !== 1'b1 || instr !== 32'h01B1001B + 32'(i) || instr_pc !== 8'(8'h10 + i)) begin
                failures++;
                $display("FAIL bp_drain_%0d got=%b/%h/%h exp=1/%h/%h", i, instr_valid, instr, instr_pc, 32'h01B1001B + 32'(i), 8'(8'h10 + i));
            end
            @(negedge clk);
        end
    endtask

    task automatic test_redirect();
        bit ok;
        apply_reset();
        do_start(8'h10);
        wait_valid(10, ok);
        checks++; if (!ok) begin failures++; $display("FAIL rd_first_valid got=timeout exp=valid"); end
        repeat (2) @(negedge clk);
        redirect_valid = 1'b1;
        redirect_addr = 8'h40;
        #1;
        checks++; if (imem_rd_en !== 1'b0) begin failures++; $display("FAIL redirect_blocks_read got=%b exp=0", imem_rd_en); end
        @(negedge clk);
        redirect_valid = 1'b0;
        checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL redirect_flush got=%b exp=0", instr_valid); end
        instr_ready = 1'b1;
        wait_valid(10, ok);
        checks++;
        if (!ok || instr !== 32'h0000001F || instr_pc !== 8'h40) begin
            failures++;
            $display("FAIL redirect_word got=%b/%h/%h exp=1/0000001f/40", ok, instr, instr_pc);
        end
        @(negedge clk);
        checks++;
        if (instr_valid !== 1'b1 || instr !== 32'h01B1004C || instr_pc !== 8'h41) begin
            failures++;
            $display("FAIL redirect_next got=%b/%h/%h exp=1/01b1004c/41", instr_valid, instr, instr_pc);
        end
    endtask

    task automatic test_halt();
        int n;
        int bad_rd;
        bit ok;
        mem[8'h13] = HALT_W;
        apply_reset();
        instr_ready = 1'b1;
        do_start(8'h10);
        n = 0;
        bad_rd = 0;
        repeat (15) begin
            if (instr_valid === 1'b1) begin
                checks++;
                if (n >= 3 || instr !== 32'h01B1001B + 32'(n) || instr_pc !== 8'(8'h10 + n)) begin
                    failures++;
                    $display("FAIL halt_word_%0d got=%h/%h exp=%h/%h", n, instr, instr_pc, 32'h01B1001B + 32'(n), 8'(8'h10 + n));
                end
                n++;
            end
            if (halted === 1'b1 && imem_rd_en !== 1'b0) bad_rd++;
            @(negedge clk);
        end
        checks++; if (n != 3) begin failures++; $display("FAIL halt_count got=%0d exp=3", n); end
        checks++; if (halted !== 1'b1) begin failures++; $display("FAIL halt_flag got=%b exp=1", halted); end
        checks++; if (bad_rd != 0) begin failures++; $display("FAIL halt_no_read got=%0d exp=0", bad_rd); end
        redirect_valid = 1'b1;
        redirect_addr = 8'h20;
        @(negedge clk);
        redirect_valid = 1'b0;
        checks++; if (halted !== 1'b0) begin failures++; $display("FAIL halt_cleared got=%b exp=0", halted); end
        wait_valid(10, ok);
        checks++;
        if (!ok || instr !== 32'h01B1002B || instr_pc !== 8'h20) begin
            failures++;
            $display("FAIL halt_resume got=%b/%h/%h exp=1/01b1002b/20", ok, instr, instr_pc);
        end
        mem[8'h13] = 32'h01B1001E;
    endtask

    task automatic test_wrap();
        bit ok;
        logic [7:0] epc;
        apply_reset();
        instr_ready = 1'b1;
        do_start(8'hFE);
        wait_valid(10, ok);
        checks++; if (!ok) begin failures++; $display("FAIL wrap_first_valid got=timeout exp=valid"); end
        for (int i = 0; i < 4; i++) begin
            epc = 8'hFE + 8'(i);
            checks++;
            if (instr_valid !== 1'b1 || instr_pc !== epc || instr !== 32'h01B10000 + 32'(epc) + 32'd11) begin
                failures++;
                $display("FAIL wrap_%0d got=%b/%h/%h exp=1/%h/%h", i, instr_valid, instr, instr_pc, 32'h01B10000 + 32'(epc) + 32'd11, epc);
            end
            @(negedge clk);
        end
        instr_ready = 1'b0;
`ifdef FETCH_PERF_CNT_EN
        checks++; if (perf_fetch_cnt !== 32'd4) begin failures++; $display("FAIL perf_fetch got=%0d exp=4", perf_fetch_cnt); end
`endif
    endtask

    initial begin
        for (int a = 0; a < 256; a++) mem[a] = 32'h01B1_0000 + 32'(a) + 32'd11;
        mem[8'h40] = 32'h0000_001F;
        imem_rd_data = '0;
        test_reset();
        test_straight();
        test_backpressure();
        test_redirect();
        test_halt();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
